// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the ebreak word returned on bad fetches, and the default code base address.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] EBREAK_INST       = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // Word index of a byte pc relative to the base, with 32-bit unsigned wrap.
  function automatic logic [31:0] word_index(input logic [31:0] pc, input logic [31:0] base);
    logic [31:0] diff;
    diff = pc - base;
    return diff >> 2;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// One-write, one-read synchronous RAM; a same-address write on the read edge
// is forwarded to the read data (write-first). Contents are never reset.
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    if (re) begin
      rd <= (we && (wa == ra)) ? wd : mem[ra];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with one outstanding request,
// a backdoor program-load port, and ebreak responses for bad fetches.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, and resp_inst/resp_err stay stable
// while resp_valid=1 and resp_ready=0.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output state_e      dbg_state
);

  localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] pc_q;
  logic        err_q;

  logic        enter_resp;
  logic [31:0] sel_pc;
  logic [31:0] sel_idx;
  logic        sel_err;
  logic        ld_ok;
  logic [31:0] ram_rd;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_nx   = LAT_M1;
          state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the read happens on the accept edge, before pc_q is loaded.
  assign sel_pc     = (state == ST_IDLE) ? req_pc : pc_q;
  assign sel_idx    = word_index(sel_pc, BASE_ADDR);
  assign sel_err    = (sel_pc[1:0] != 2'b00) || (sel_pc < BASE_ADDR) ||
                      (sel_idx >= 32'(DEPTH_WORDS));
  assign enter_resp = (state_nx == ST_RESP) && (state != ST_RESP);
  assign ld_ok      = ld_en && (ld_addr < 32'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      pc_q  <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == ST_IDLE && req_valid) begin
        pc_q <= req_pc;
      end
      if (enter_resp) begin
        err_q <= sel_err;
      end
    end
  end

  imem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk (clk),
    .we  (ld_ok),
    .wa  (ld_addr[AW-1:0]),
    .wd  (ld_data),
    .re  (enter_resp && !sel_err),
    .ra  (sel_idx[AW-1:0]),
    .rd  (ram_rd)
  );

  // Outputs decode from the reset-cleared state so reset takes effect at once.
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_inst  = !resp_valid ? 32'd0 : (err_q ? EBREAK_INST : ram_rd);
  assign dbg_state  = state;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table of fetches plus hand-written
// sequences for stall, write-first forwarding and mid-fetch reset.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } vec_t;
  vec_t vecs[10];

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input logic err);
    logic [32:0] exp;
    exp_q.push_back({err, inst});
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_pc = pc;
    @(negedge clk);
    req_valid = 1'b0; req_pc = '0;
    for (int k = 1; k < LAT; k++) begin
      chk("resp_early", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    exp = exp_q.pop_front();
    chk("resp_inst", resp_inst, exp[31:0]);
    chk("resp_err", 32'(resp_err), 32'(exp[32]));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held_inst;

    rst = 1'b1; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h00a0_0093, 1'b0};
    vecs[2] = '{32'h8000_0008, 32'hdead_beef, 1'b0};
    vecs[3] = '{32'h8000_003C, 32'hcafe_f00d, 1'b0};
    vecs[4] = '{32'h8000_0002, EBREAK_INST,   1'b1};
    vecs[5] = '{32'h8000_0001, EBREAK_INST,   1'b1};
    vecs[6] = '{32'h7FFF_FFFC, EBREAK_INST,   1'b1};
    vecs[7] = '{BASE + 32'(4 * DEPTH), EBREAK_INST, 1'b1};
    vecs[8] = '{32'hFFFF_FFFC, EBREAK_INST,   1'b1};
    vecs[9] = '{32'h0000_0000, EBREAK_INST,   1'b1};

    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_inst", resp_inst, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load(32'd0,  32'h0000_0413);
    load(32'd1,  32'h00a0_0093);
    load(32'd2,  32'hdead_beef);
    load(32'd15, 32'hcafe_f00d);
    // Out-of-range loads must not alias onto low words.
    load(32'd16, 32'hbad0_bad0);
    load(32'hFFFF_FFFF, 32'hbad1_bad1);

    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].pc, vecs[i].inst, vecs[i].err);
    end

    // Stall in RESP for 5 cycles; stray requests and loads must not disturb it.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 32'h8000_0004;
    @(negedge clk);
    req_pc = 32'h8000_0000;
    @(negedge clk);
    chk("stall_valid0", 32'(resp_valid), 32'd1);
    chk("stall_inst0", resp_inst, 32'h00a0_0093);
    held_inst = resp_inst;
    ld_en = 1'b1; ld_addr = 32'd1; ld_data = 32'h1111_2222;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ld_en = 1'b0;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_inst", resp_inst, held_inst);
      chk("stall_err", 32'(resp_err), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; req_pc = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("stall_release_ready", 32'(req_ready), 32'd1);
    chk("stall_release_valid", 32'(resp_valid), 32'd0);
    fetch(32'h8000_0004, 32'h1111_2222, 1'b0);

    // Load the pending word on the edge that enters RESP: new data is returned.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 32'h8000_0008;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wf_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    ld_en = 1'b1; ld_addr = 32'd2; ld_data = 32'h5555_aaaa;
    @(negedge clk);
    ld_en = 1'b0;
    chk("wf_valid", 32'(resp_valid), 32'd1);
    chk("wf_inst", resp_inst, 32'h5555_aaaa);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0);

    // Reset in WAIT: outputs clear at once and the fetch is never answered.
    @(negedge clk);
    req_valid = 1'b1; req_pc = 32'h8000_0004;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("mid_wait_ready", 32'(req_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_inst", resp_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    fetch(32'h8000_003C, 32'hcafe_f00d, 1'b0);
    fetch(32'h8000_0006, EBREAK_INST, 1'b1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
